// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
// Holds the controller state enum and the pipeline latency derivation.
package systolic_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PE_ROW     = 16;
    localparam int DEF_PE_COL     = 16;

    // skew (rows-1) + array traversal (cols) + input and output buffer regs
    function automatic int calc_pipe_lat(input int rows, input int cols);
        return (rows - 1) + cols + 2;
    endfunction

    localparam int DEF_PIPE_LAT = calc_pipe_lat(DEF_PE_ROW, DEF_PE_COL);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        SAVE,
        GAP,
        STREAM,
        DRAIN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/systolic_valid_delay.sv
// Window generator: a start pulse opens a valid window of i_len cycles
// beginning PIPE_LAT cycles after the pulse. o_last marks the final cycle.
module systolic_valid_delay
    import systolic_pkg::*;
#(
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int LEN_W    = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_valid,
    output logic             o_last
);

    localparam int CW = LEN_W + 1;
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_LAT = CW'(PIPE_LAT);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_end;
    logic          w_last;

    assign w_last  = r_active && (r_cnt == r_end);
    assign o_valid = r_active && (r_cnt >= C_LAT);
    assign o_last  = w_last;

    // r_cnt is the offset from the start pulse; r_end is the last valid offset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_end    <= '0;
        end else if (i_start && (i_len != '0)) begin
            r_active <= 1'b1;
            r_cnt    <= C_ONE;
            r_end    <= C_LAT + {1'b0, i_len} - C_ONE;
        end else if (r_active) begin
            r_cnt <= r_cnt + C_ONE;
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Weight/activation sequencer feeding the weight-stationary systolic array.
// Optional SYSTOLIC_CTRL_PERF_EN adds a busy-cycle counter port perf_cycles.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PE_ROW     = DEF_PE_ROW,
    parameter int PE_COL     = DEF_PE_COL,
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 10,
    parameter int PIPE_LAT   = DEF_PIPE_LAT
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            w_base,
    input  logic [ADDR_W-1:0]            a_base,
    input  logic [CNT_W-1:0]             num_vec,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_rd_addr,
    input  logic [PE_COL*DATA_WIDTH-1:0] mem_rd_data,
    output logic [PE_COL*DATA_WIDTH-1:0] din,
    output logic                         load_weight,
    output logic                         save,
    output logic [PE_ROW-1:0]            enable,
    output logic                         out_valid,
    output logic                         busy,
`ifdef SYSTOLIC_CTRL_PERF_EN
    output logic [31:0]                  perf_cycles,
`endif
    output logic                         done
);

    localparam int CW = CNT_W + 1;
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [CW-1:0] C_LAST_W = CW'(PE_ROW);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [ADDR_W-1:0] r_w_base;
    logic [ADDR_W-1:0] r_a_base;
    logic [CNT_W-1:0]  r_num_vec;
    logic [CW-1:0]     w_nv_ext;
    logic [ADDR_W-1:0] w_wb;
    logic              w_accept;

    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_din_sel;
    logic [PE_ROW-1:0] r_enable;
    logic              w_rd_en_nxt;
    logic [ADDR_W-1:0] w_rd_addr_nxt;
    logic              w_din_sel_nxt;
    logic [PE_ROW-1:0] w_enable_nxt;

    logic              w_vd_start;
    logic              w_vd_last;

    assign w_accept = (r_state == IDLE) && start;
    assign w_nv_ext = {1'b0, r_num_vec};
    assign w_wb     = (r_state == IDLE) ? w_base : r_w_base;

    assign load_weight = (r_state == LOAD_W) && (r_cnt != '0);
    assign save        = (r_state == SAVE);
    assign done        = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign enable      = r_enable;
    assign din         = r_din_sel ? mem_rd_data : '0;
    assign w_vd_start  = (r_state == STREAM) && (r_cnt == '0);

    // State and phase counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Job parameters captured when a start is accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_w_base  <= '0;
            r_a_base  <= '0;
            r_num_vec <= '0;
        end else if (w_accept) begin
            r_w_base  <= w_base;
            r_a_base  <= a_base;
            r_num_vec <= num_vec;
        end
    end

    // Next state, next count, and next values of the registered outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = '0;
        w_din_sel_nxt = 1'b0;
        w_enable_nxt  = '0;

        unique case (r_state)
            IDLE:   if (start) w_state_nxt = LOAD_W;
            LOAD_W: if (r_cnt == C_LAST_W) w_state_nxt = SAVE;
            SAVE:   w_state_nxt = (r_num_vec == '0) ? DONE : GAP;
            GAP:    w_state_nxt = STREAM;
            STREAM: if (r_cnt + C_ONE == w_nv_ext) w_state_nxt = DRAIN;
            DRAIN:  if (w_vd_last) w_state_nxt = DONE;
            DONE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        if ((w_state_nxt == r_state) &&
            ((r_state == LOAD_W) || (r_state == STREAM))) begin
            w_cnt_nxt = r_cnt + C_ONE;
        end else begin
            w_cnt_nxt = '0;
        end

        unique case (w_state_nxt)
            LOAD_W: begin
                if (w_cnt_nxt < C_LAST_W) begin
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = w_wb + ADDR_W'(w_cnt_nxt);
                end
                w_din_sel_nxt = (w_cnt_nxt != '0);
            end
            GAP: begin
                w_rd_en_nxt   = 1'b1;
                w_rd_addr_nxt = r_a_base;
            end
            STREAM: begin
                w_din_sel_nxt = 1'b1;
                if (w_cnt_nxt + C_ONE < w_nv_ext) begin
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = r_a_base + ADDR_W'(w_cnt_nxt + C_ONE);
                end
                if (r_state == STREAM) begin
                    w_enable_nxt = {r_enable[PE_ROW-2:0], 1'b1};
                end
            end
            DRAIN: begin
                w_enable_nxt = {r_enable[PE_ROW-2:0], 1'b1};
            end
            default: begin
                w_enable_nxt = '0;
            end
        endcase
    end

    // Registered array-side and buffer-side outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_din_sel <= 1'b0;
            r_enable  <= '0;
        end else begin
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_din_sel <= w_din_sel_nxt;
            r_enable  <= w_enable_nxt;
        end
    end

    systolic_valid_delay #(
        .PIPE_LAT (PIPE_LAT),
        .LEN_W    (CNT_W)
    ) u_valid_delay (
        .clk     (clk),
        .rstn    (rstn),
        .i_start (w_vd_start),
        .i_len   (r_num_vec),
        .o_valid (out_valid),
        .o_last  (w_vd_last)
    );

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] r_perf;

    // Busy-cycle count for the current job, saturating
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if (busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Testbench for systolic_ctrl: timeline model of each job plus pinned literals.
// A simple 1-cycle-latency buffer model serves weight and activation reads.
module tb_systolic_ctrl;

    logic         clk;
    logic         rstn;
    logic         start;
    logic [9:0]   w_base;
    logic [9:0]   a_base;
    logic [9:0]   num_vec;
    logic         mem_rd_en;
    logic [9:0]   mem_rd_addr;
    logic [127:0] mem_rd_data = '0;
    logic [127:0] din;
    logic         load_weight;
    logic         save;
    logic [15:0]  enable;
    logic         out_valid;
    logic         busy;
    logic         done;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]  perf_cycles;
`endif

    systolic_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .w_base      (w_base),
        .a_base      (a_base),
        .num_vec     (num_vec),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .din         (din),
        .load_weight (load_weight),
        .save        (save),
        .enable      (enable),
        .out_valid   (out_valid),
        .busy        (busy),
`ifdef SYSTOLIC_CTRL_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .done        (done)
    );

    logic [127:0] mem [1024];
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    bit have_job = 0;
    int t0 = 0;
    int m_n = 0;
    int m_wb = 0;
    int m_ab = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ramp(input int m);
        if (m >= 16) return 16'hFFFF;
        return 16'((32'd1 << m) - 1);
    endfunction

    function automatic int done_at(input int n);
        return (n == 0) ? 19 : 53 + n;
    endfunction

    // Expected outputs at offset t from the cycle the start was accepted
    task automatic model(input int t, input int n, input int wb, input int ab,
                         output logic e_rd, output logic [9:0] e_addr,
                         output logic [127:0] e_din, output logic e_lw,
                         output logic e_sv, output logic [15:0] e_en,
                         output logic e_ov, output logic e_busy,
                         output logic e_done);
        int dt;
        int j;
        dt = done_at(n);
        e_rd = 0; e_addr = '0; e_din = '0; e_lw = 0; e_sv = 0;
        e_en = '0; e_ov = 0;
        e_busy = (t >= 1) && (t <= dt);
        e_done = (t == dt);
        if (t >= 1 && t <= 17) begin
            if (t <= 16) begin
                e_rd = 1;
                e_addr = 10'(wb + t - 1);
            end
            if (t >= 2) begin
                e_lw = 1;
                e_din = mem[10'(wb + t - 2)];
            end
        end
        if (t == 18) e_sv = 1;
        if (n > 0) begin
            if (t == 19) begin
                e_rd = 1;
                e_addr = 10'(ab);
            end
            if (t >= 20 && t < 20 + n) begin
                j = t - 20;
                e_din = mem[10'(ab + j)];
                if (j + 1 < n) begin
                    e_rd = 1;
                    e_addr = 10'(ab + j + 1);
                end
            end
            if (t >= 20 && t < dt) e_en = ramp(t - 20);
            if (t >= 53 && t < 53 + n) e_ov = 1;
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic e_rd, e_lw, e_sv, e_ov, e_busy, e_done;
        logic [9:0] e_addr;
        logic [127:0] e_din;
        logic [15:0] e_en;
        if (rstn && have_job) begin
            model(cyc - t0, m_n, m_wb, m_ab, e_rd, e_addr, e_din, e_lw,
                  e_sv, e_en, e_ov, e_busy, e_done);
        end else begin
            e_rd = 0; e_addr = '0; e_din = '0; e_lw = 0; e_sv = 0;
            e_en = '0; e_ov = 0; e_busy = 0; e_done = 0;
        end
        chk("mem_rd_en", mem_rd_en, e_rd);
        if (e_rd) chk("mem_rd_addr", mem_rd_addr, e_addr);
        chk("din", din, e_din);
        chk("load_weight", load_weight, e_lw);
        chk("save", save, e_sv);
        chk("enable", enable, e_en);
        chk("out_valid", out_valid, e_ov);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
    end

    function automatic bit model_busy();
        int t;
        if (!have_job) return 0;
        t = cyc - t0;
        return (t >= 1) && (t <= done_at(m_n));
    endfunction

    task automatic start_job(input int wb, input int ab, input int n);
        @(posedge clk); #1;
        w_base = 10'(wb);
        a_base = 10'(ab);
        num_vec = 10'(n);
        start = 1'b1;
        if (!model_busy()) begin
            have_job = 1;
            t0 = cyc;
            m_n = n;
            m_wb = wb;
            m_ab = ab;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Park at the negedge of the cycle at offset k of the current job
    task automatic goto_t(input int k);
        while (cyc < t0 + k) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++)
            for (int i = 0; i < 16; i++)
                mem[a][i*8 +: 8] = 8'(a * 3 + i * 5 + 1);
        for (int r = 0; r < 16; r++)
            mem[10'h100 + r] = {16{8'(16 - r)}};
        for (int j = 0; j < 16; j++)
            for (int i = 0; i < 16; i++)
                mem[10'h200 + j][i*8 +: 8] = 8'(j * 16 + i);

        rstn = 1'b0; start = 1'b0;
        w_base = '0; a_base = '0; num_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_enable", enable, 0);
        chk("rst_din", din, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Full job: 16 weights then 16 vectors, with an ignored start
        start_job(10'h100, 10'h200, 16);
        goto_t(1);
        chk("A_rd_en_k0", mem_rd_en, 1);
        chk("A_addr_k0", mem_rd_addr, 10'h100);
        goto_t(2);
        chk("A_din_row0", din, 128'h10101010101010101010101010101010);
        chk("A_lw_first", load_weight, 1);
        goto_t(16);
        chk("A_addr_k15", mem_rd_addr, 10'h10F);
        goto_t(17);
        chk("A_din_row15", din, 128'h01010101010101010101010101010101);
        goto_t(18);
        chk("A_save", save, 1);
        chk("A_lw_off", load_weight, 0);
        goto_t(20);
        chk("A_din_vec0", din, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("A_en_j0", enable, 16'h0000);
        goto_t(21);
        chk("A_din_vec1", din, 128'h1F1E1D1C1B1A19181716151413121110);
        chk("A_en_j1", enable, 16'h0001);
        goto_t(24);
        start_job(10'h000, 10'h000, 3);
        goto_t(27);
        chk("A_addr_after_ign", mem_rd_addr, 10'h208);
        goto_t(36);
        chk("A_en_full", enable, 16'hFFFF);
        goto_t(52);
        chk("A_ov_before", out_valid, 0);
        goto_t(53);
        chk("A_ov_first", out_valid, 1);
        goto_t(68);
        chk("A_ov_last", out_valid, 1);
        goto_t(69);
        chk("A_done", done, 1);
        chk("A_ov_closed", out_valid, 0);
        goto_t(70);
        chk("A_busy_low", busy, 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        goto_t(72);
        chk("A_perf", perf_cycles, 32'd69);
`endif
        goto_t(73);

        // num_vec = 0: weights only
        start_job(10'h100, 10'h200, 0);
        goto_t(18);
        chk("B_save", save, 1);
        goto_t(19);
        chk("B_done", done, 1);
        chk("B_no_act_read", mem_rd_en, 0);
        goto_t(22);

        // num_vec = 1
        start_job(10'h100, 10'h200, 1);
        goto_t(20);
        chk("C_en_j0", enable, 16'h0000);
        goto_t(21);
        chk("C_en_drain", enable, 16'h0001);
        goto_t(53);
        chk("C_ov", out_valid, 1);
        goto_t(54);
        chk("C_done", done, 1);
        goto_t(56);

        // Activation address wrap
        start_job(10'h100, 10'h3FF, 3);
        goto_t(19);
        chk("D_addr_3ff", mem_rd_addr, 10'h3FF);
        goto_t(20);
        chk("D_addr_wrap", mem_rd_addr, 10'h000);
        goto_t(21);
        chk("D_addr_001", mem_rd_addr, 10'h001);
        goto_t(56);
        chk("D_done", done, 1);
        goto_t(58);

        // Reset in the middle of DRAIN
        start_job(10'h100, 10'h200, 16);
        goto_t(45);
        #2;
        have_job = 0;
        rstn = 1'b0;
        #1;
        chk("E_busy_rst", busy, 0);
        chk("E_enable_rst", enable, 0);
        chk("E_din_rst", din, 0);
        chk("E_done_rst", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (60) @(posedge clk);

        // Clean job after reset
        start_job(10'h100, 10'h200, 4);
        goto_t(20);
        chk("F_din_vec0", din, 128'h0F0E0D0C0B0A09080706050403020100);
        goto_t(57);
        chk("F_done", done, 1);
        goto_t(60);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
